// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky error flags, synchronous flush and optional FWFT read
// Ports: clk, rst_n (async active-low); clr (sync flush); wr_en/data_in (write side); rd_en/data_out (read side, pop in FWFT);
//        full, empty, almost_full, almost_empty, count (occupancy 0..DEPTH); overflow, underflow (sticky until clr or reset).
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through data_out; default is a registered read with 1-cycle latency.
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  // flags decode the count register directly, so they never lag it
  assign full         = count == DEPTH_C;
  assign empty        = count == '0;
  assign almost_full  = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign wr_acc = wr_en & ~full & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + ADDR_WIDTH'(wr_acc);
      rd_ptr    <= rd_ptr + ADDR_WIDTH'(rd_acc);
      count     <= count + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
      overflow  <= overflow | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
`ifdef SYNC_FIFO_FWFT_EN
  // head entry is always visible; contents are meaningless while empty
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: scoreboard bench for sync_fifo_flex (default parameters, either read mode)
module tb_sync_fifo_flex;
  localparam int DEPTH = 16;
  logic clk, rst_n, clr, wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic [7:0] q[$];
  logic [7:0] mdout;
  logic movf, mudf;
  int checks, errors;
  sync_fifo_flex dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    int n;
    n = q.size();
    check("count", 32'(count), n);
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(n <= 2));
    check("overflow", 32'(overflow), 32'(movf));
    check("underflow", 32'(underflow), 32'(mudf));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) check("data_out", 32'(data_out), 32'(q[0]));
`else
    check("data_out", 32'(data_out), 32'(mdout));
`endif
  endtask
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic e, f;
    e = q.size() == 0;
    f = q.size() == DEPTH;
`ifdef SYNC_FIFO_FWFT_EN
    if (r && !e) check("fwft_head", 32'(data_out), 32'(q[0]));
`endif
    wr_en = w;
    rd_en = r;
    data_in = d;
    if (w && f) movf = 1;
    if (r && e) mudf = 1;
    if (r && !e) mdout = q.pop_front();
    if (w && !f) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 0;
    rd_en = 0;
    check_state();
  endtask
  task automatic do_clr();
    clr = 1;
    wr_en = 1;
    rd_en = 1;
    data_in = 8'hEE;
    q.delete();
    movf = 0;
    mudf = 0;
    @(posedge clk);
    #1;
    clr = 0;
    wr_en = 0;
    rd_en = 0;
    check_state();
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 0;
    clr = 0;
    wr_en = 0;
    rd_en = 0;
    data_in = 0;
    mdout = 0;
    movf = 0;
    mudf = 0;
    #12;
    check_state();
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 16; i++) cycle(1, 0, 8'(i));
    cycle(1, 0, 8'h11);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);
    cycle(0, 1, 8'h00);
    do_clr();
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 40; i++) cycle(1, 1, 8'(8'h40 + i));
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h80 + i));
    cycle(1, 1, 8'hFF);
    for (int i = 0; i < 15; i++) cycle(0, 1, 8'h00);
    do_clr();
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hC0 + i));
    do_clr();
    cycle(1, 0, 8'h77);
    cycle(0, 1, 8'h00);
    cycle(1, 0, 8'hA5);
    cycle(0, 0, 8'h00);
    cycle(0, 1, 8'h00);
    for (int i = 0; i < 9; i++) cycle(1, 0, 8'(8'h60 + i));
    cycle(1, 1, 8'h70);
    wr_en = 1;
    rd_en = 1;
    data_in = 8'h71;
    #3;
    rst_n = 0;
    #1;
    q.delete();
    movf = 0;
    mudf = 0;
    mdout = 0;
    check_state();
    @(posedge clk);
    #1;
    check_state();
    wr_en = 0;
    rd_en = 0;
    rst_n = 1;
    cycle(1, 0, 8'h5A);
    cycle(0, 1, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, the next generation of the team's FIFO buffering blocks. It is generalised in data width and depth. It adds the following over the previous FIFO:
- occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- compile-time first-word-fall-through (FWFT) read mode

It sits between same-clock producer and consumer stages wherever rate smoothing or back-pressure is needed.

## Interface
- DATA_WIDTH, 8: width of data_in/data_out in bits (>= 1).
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH (>= 1).
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= this value (1..DEPTH).
- AEMPTY_THRESH, 2: almost_empty asserts when count <= this value (0..DEPTH-1).
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush; empties the FIFO and clears error flags.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
- rd_en  input  1  read request (pop in FWFT mode).
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH x DATA_WIDTH array.
- wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap modulo DEPTH with no special case.
- Write accept: wr_acc = wr_en & ~full & ~clr. An accepted write stores data_in at wr_ptr and increments wr_ptr.
- Read accept: rd_acc = rd_en & ~empty & ~clr. An accepted read increments rd_ptr.
- Count: count_next = count + wr_acc - rd_acc.
  - Both accepted in one cycle: count unchanged, both pointers advance.
- Full plus simultaneous wr_en and rd_en: only the read is accepted. The write is rejected and overflow sets; count drops to DEPTH-1.
- Empty plus simultaneous wr_en and rd_en: only the write is accepted. The read is rejected and underflow sets; count becomes 1.
- Flags full, empty, almost_full and almost_empty are pure decodes of the count register. They carry no extra register stage.
- overflow sets on wr_en & full & ~clr; underflow sets on rd_en & empty & ~clr. Both hold until clr or reset.
- clr has priority over wr_en and rd_en. On clr the next edge gives:
  - pointers = 0, count = 0, overflow = 0, underflow = 0
  - storage contents unchanged
  - data_out unchanged in standard mode
- Reset (rst_n low, at any time, including mid-transfer) immediately forces:
  - pointers = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (AFULL_THRESH >= 1)
  - overflow = 0, underflow = 0
  - data_out = 0 in standard mode
  - Storage is not reset.
- Release of reset is synchronous to clk. The block accepts traffic from the first edge after rst_n rises.

## Timing
- Write-to-flag: count and all flags update on the same edge that accepts the write or read.
- Standard mode:
  - data_out is a register, loaded with mem[rd_ptr] on the edge that accepts a read.
  - Valid from that edge (1-cycle read latency); holds otherwise.
- Write-to-read: a word written at edge N can be accepted by a read at edge N+1. It appears on data_out after edge N+1 (standard) or after edge N (FWFT).
- No combinational path from wr_en/rd_en to any output. The exception is FWFT data_out, which depends only on rd_ptr and storage.

## Configuration
- SYNC_FIFO_FWFT_EN defined:
  - data_out continuously shows mem[rd_ptr], the head entry, whenever empty = 0.
  - rd_en acts as a pop: the next entry is visible after the accepting edge.
  - data_out is undefined while empty = 1; the bench does not check it then.
  - No data_out reset value.
- Not defined: standard registered-read mode as described in Timing.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then DEPTH=16 defaults: count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, data_out = 0 (standard).
- Write 0x01..0x10 on 16 consecutive cycles:
  - almost_full asserts after the 14th write (count = 14); full asserts after the 16th.
  - A 17th write sets overflow, and count stays 16.
  - Reading all 16 returns 0x01..0x10 in order; the next read sets underflow.
- Ring wrap: 40 cycles of simultaneous write/read at count = 8. count stays 8 throughout, and data order is preserved across pointer wrap.
- At full, assert wr_en and rd_en together: read accepted, write dropped, overflow = 1, count = 15.
- Write 5 words, then pulse clr with wr_en = rd_en = 1. Next cycle: count = 0, empty = 1, overflow = underflow = 0, and no data written or read on the clr cycle.
- FWFT build: write 0xA5 into an empty FIFO. After that edge, empty = 0 and data_out = 0xA5 with no rd_en. Pulse rd_en: empty = 1 after the edge.
- Assert rst_n low while count = 9 with traffic active: all outputs take reset values immediately, without waiting for a clock edge.
